// File: rtl/axis_register_fifo.sv
// AXI4-Stream FIFO of `depth` beats: a beat pushed at one edge is visible the cycle after (no bypass).
// Backpressure: s_axis_tready comes only from stored state. Packet mode holds output until a tlast beat is held or the buffer is full.
module axis_register_fifo #(
  parameter int data_width  = 8,
  parameter int depth       = 4,
  parameter int packet_mode = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [data_width-1:0]   data_in,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [data_width-1:0]   data_out,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [$clog2(depth):0]  count,
  output logic [$clog2(depth):0]  pkt_count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_count = cnt_w'(depth);
  localparam logic [cnt_w-1:0] cnt_one    = cnt_w'(1);

  // Each entry is {tlast, data}. Contents are not reset; the outputs are gated by count.
  logic [data_width:0] mem [depth];
  logic [ptr_w-1:0]    wr_ptr;
  logic [ptr_w-1:0]    rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                head_last;
  logic                pkt_inc;
  logic                pkt_dec;

  assign empty     = (count == '0);
  assign full      = (count == full_count);
  assign head_last = mem[rd_ptr][data_width];

  assign s_axis_tready = !full;
  // Releasing on a full buffer lets packets longer than the buffer drain.
  assign m_axis_tvalid = (packet_mode != 0) ? (!empty && ((pkt_count != '0) || full))
                                            : !empty;
  assign data_out      = mem[rd_ptr][data_width-1:0];
  assign m_axis_tlast  = head_last && !empty;

  assign push    = s_axis_tvalid && s_axis_tready;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign pkt_inc = push && s_axis_tlast;
  assign pkt_dec = pop && head_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + cnt_one;
      else if (pop && !push) count <= count - cnt_one;
      if (pkt_inc && !pkt_dec)      pkt_count <= pkt_count + cnt_one;
      else if (pkt_dec && !pkt_inc) pkt_count <= pkt_count - cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, data_in};
  end

endmodule

// File: tb/tb_axis_register_fifo.sv
// Bench for axis_register_fifo: one streaming instance and one packet-mode instance share inputs,
// each compared every cycle against a queue model, plus a vector table and directed corner sequences.
module tb_axis_register_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready;

  logic       s_rdy0, v0, l0, s_rdy1, v1, l1;
  logic [7:0] d0, d1;
  logic [2:0] c0, p0, c1, p1;

  axis_register_fifo #(.data_width(8), .depth(DEPTH), .packet_mode(0)) u_stream (
    .clk(clk), .reset(reset), .data_in(data_in), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy0), .data_out(d0), .m_axis_tvalid(v0),
    .m_axis_tlast(l0), .m_axis_tready(m_tready), .count(c0), .pkt_count(p0));

  axis_register_fifo #(.data_width(8), .depth(DEPTH), .packet_mode(1)) u_packet (
    .clk(clk), .reset(reset), .data_in(data_in), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy1), .data_out(d1), .m_axis_tvalid(v1),
    .m_axis_tlast(l1), .m_axis_tready(m_tready), .count(c1), .pkt_count(p1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: ordered queue of stored {tlast, data} beats per instance.
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mdl_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] mdl_at(input int k, input int i);
    return (k == 0) ? q0[i] : q1[i];
  endfunction

  function automatic int mdl_pkts(input int k);
    int n = 0;
    for (int i = 0; i < mdl_size(k); i++) if (mdl_at(k, i)[8]) n++;
    return n;
  endfunction

  function automatic bit mdl_vld(input int k);
    if (mdl_size(k) == 0) return 1'b0;
    if (k == 0) return 1'b1;
    return (mdl_pkts(k) != 0) || (mdl_size(k) == DEPTH);
  endfunction

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int         a_cnt, a_pkt, a_rdy, a_vld, a_last, a_dat;
      logic [8:0] head;
      if (k == 0) begin
        a_cnt = c0; a_pkt = p0; a_rdy = s_rdy0; a_vld = v0; a_last = l0; a_dat = d0;
      end else begin
        a_cnt = c1; a_pkt = p1; a_rdy = s_rdy1; a_vld = v1; a_last = l1; a_dat = d1;
      end
      head = (mdl_size(k) != 0) ? mdl_at(k, 0) : 9'h0;
      chk($sformatf("m%0d count", k), a_cnt, mdl_size(k));
      chk($sformatf("m%0d pkt_count", k), a_pkt, mdl_pkts(k));
      chk($sformatf("m%0d s_tready", k), a_rdy, int'(mdl_size(k) != DEPTH));
      chk($sformatf("m%0d m_tvalid", k), a_vld, int'(mdl_vld(k)));
      chk($sformatf("m%0d m_tlast", k), a_last, int'(head[8]));
      if (mdl_vld(k)) chk($sformatf("m%0d data_out", k), a_dat, int'(head[7:0]));
    end
  endtask

  // Drive one cycle's inputs at the falling edge and compare state-derived outputs.
  task automatic drive(input logic rst, input logic tv, input logic tl,
                       input logic [7:0] d, input logic rdy);
    @(negedge clk);
    reset = rst; s_tvalid = tv; s_tlast = tl; data_in = d; m_tready = rdy;
    model_check();
  endtask

  task automatic tick();
    bit push0, pop0, push1, pop1;
    push0 = s_tvalid && (mdl_size(0) != DEPTH);
    push1 = s_tvalid && (mdl_size(1) != DEPTH);
    pop0  = mdl_vld(0) && m_tready;
    pop1  = mdl_vld(1) && m_tready;
    @(posedge clk);
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0)  void'(q0.pop_front());
      if (pop1)  void'(q1.pop_front());
      if (push0) q0.push_back({s_tlast, data_in});
      if (push1) q1.push_back({s_tlast, data_in});
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
  endtask

  typedef struct {
    logic       tv;
    logic       tl;
    logic [7:0] dat;
    logic       rdy;
    int         e_cnt;
    int         e_pkt;
    logic       e_srdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_last;
  } vec_t;

  vec_t vt[15];
  logic [7:0] got[$];
  int idx;
  int first_cnt;
  bit acc;

  initial begin
    reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; data_in = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state of the streaming instance.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset s_tready", s_rdy0, 1);
    chk("reset m_tvalid", v0, 0);
    chk("reset m_tlast", l0, 0);
    chk("reset count", c0, 0);
    tick();

    // Streaming instance: fill against backpressure, full push/pop, drain, no-bypass.
    vt[0]  = '{1, 0, 8'h11, 0, 0, 0, 1, 0, 8'h00, 0};
    vt[1]  = '{1, 0, 8'h12, 0, 1, 0, 1, 1, 8'h11, 0};
    vt[2]  = '{1, 0, 8'h13, 0, 2, 0, 1, 1, 8'h11, 0};
    vt[3]  = '{1, 1, 8'h14, 0, 3, 0, 1, 1, 8'h11, 0};
    vt[4]  = '{1, 0, 8'h15, 0, 4, 1, 0, 1, 8'h11, 0};
    vt[5]  = '{1, 0, 8'h15, 1, 4, 1, 0, 1, 8'h11, 0};
    vt[6]  = '{1, 0, 8'h15, 0, 3, 1, 1, 1, 8'h12, 0};
    vt[7]  = '{0, 0, 8'h00, 1, 4, 1, 0, 1, 8'h12, 0};
    vt[8]  = '{0, 0, 8'h00, 1, 3, 1, 1, 1, 8'h13, 0};
    vt[9]  = '{0, 0, 8'h00, 1, 2, 1, 1, 1, 8'h14, 1};
    vt[10] = '{0, 0, 8'h00, 1, 1, 0, 1, 1, 8'h15, 0};
    vt[11] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0};
    vt[12] = '{1, 1, 8'h21, 1, 0, 0, 1, 0, 8'h00, 0};
    vt[13] = '{0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h21, 1};
    vt[14] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0};
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, vt[i].tv, vt[i].tl, vt[i].dat, vt[i].rdy);
      chk($sformatf("vec%0d count", i), c0, vt[i].e_cnt);
      chk($sformatf("vec%0d pkt_count", i), p0, vt[i].e_pkt);
      chk($sformatf("vec%0d s_tready", i), s_rdy0, vt[i].e_srdy);
      chk($sformatf("vec%0d m_tvalid", i), v0, vt[i].e_vld);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d data_out", i), d0, vt[i].e_dat);
        chk($sformatf("vec%0d m_tlast", i), l0, vt[i].e_last);
      end
      tick();
    end

    // Streaming throughput: 0x01..0x08 back to back with tlast on 0x08.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i < 8, i == 7, 8'(i + 1), 1'b1);
      if (i >= 1 && i <= 8) begin
        chk("stream data", d0, i);
        chk("stream tlast", l0, int'(i == 8));
      end
      chk("stream count<=1", int'(c0 <= 1), 1);
      tick();
    end

    // Packet mode: beats with gaps stay hidden until the cycle after tlast is pushed.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 8'hA0, 1'b1); chk("pkt hold A0", v1, 0); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); chk("pkt hold gap1", v1, 0); tick();
    drive(1'b0, 1'b1, 1'b0, 8'hA1, 1'b1); chk("pkt hold A1", v1, 0); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); chk("pkt hold gap2", v1, 0); tick();
    drive(1'b0, 1'b1, 1'b1, 8'hA2, 1'b1); chk("pkt hold A2", v1, 0); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); chk("pkt release vld", v1, 1); chk("pkt release A0", d1, 8'hA0); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); chk("pkt A1", d1, 8'hA1); tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); chk("pkt A2", d1, 8'hA2); chk("pkt A2 last", l1, 1); tick();

    // Packet mode: 6-beat packet through 4 entries must drain via the full-buffer release.
    do_reset();
    idx = 0; first_cnt = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      drive(1'b0, idx < 6, idx == 5, 8'(8'hB0 + idx), 1'b1);
      acc = (idx < 6) && s_rdy1;
      if (v1) begin
        if (first_cnt < 0) first_cnt = c1;
        got.push_back(d1);
      end
      tick();
      if (acc) idx++;
    end
    chk("long pkt beats out", got.size(), 6);
    chk("long pkt first release on full", first_cnt, DEPTH);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("long pkt beat%0d", i), got[i], 8'hB0 + i);

    // Reset mid-operation with handshakes active in the reset cycle.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 8'hC0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 8'hC1, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 8'hC2, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
    chk("pre-reset count", c0, 3);
    chk("pre-reset pkt_count", p0, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("post-reset count", c0, 0);
    chk("post-reset pkt_count", p0, 0);
    chk("post-reset m_tvalid", v0, 0);
    chk("post-reset s_tready", s_rdy0, 1);
    chk("post-reset pm count", c1, 0);
    chk("post-reset pm m_tvalid", v1, 0);
    tick();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            8'($urandom), $urandom_range(0, 9) < 6);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_register_fifo.md
# axis_register_fifo

Parametrised AXI4-Stream buffer: a successor to the single-entry stream register, holding `depth` beats of `data_in`/tlast with full one-beat-per-cycle throughput in both directions. Optional packet mode holds output until a complete packet (tlast beat) is stored. Sits between any two stream stages in the datapath to absorb backpressure and decouple ready timing.

## Interface
- `data_width`, 8, beat width in bits
- `depth`, 4, number of stored beats; power of two, >= 2
- `packet_mode`, 0, 1 = release beats only once a whole packet (or a full buffer) is held
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `data_in`  in  data_width  slave beat data
- `s_axis_tvalid`  in  1  slave beat valid
- `s_axis_tlast`  in  1  slave last beat of packet
- `s_axis_tready`  out  1  buffer can accept a beat
- `data_out`  out  data_width  master beat data
- `m_axis_tvalid`  out  1  master beat valid
- `m_axis_tlast`  out  1  master last beat of packet
- `m_axis_tready`  in  1  downstream accepts beat
- `count`  out  $clog2(depth)+1  beats currently stored
- `pkt_count`  out  $clog2(depth)+1  tlast beats currently stored

## Operation
- Storage: `depth` entries of {tlast, data}; write pointer, read pointer, each $clog2(depth) bits, wrap modulo depth naturally.
- push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
- push: entry[wr_ptr] <= {s_axis_tlast, data_in}; wr_ptr++.
- pop: rd_ptr++.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- pkt_count: +1 on push with tlast, -1 on pop of a tlast entry; both same cycle -> unchanged.
- s_axis_tready = (count != depth); registered-state only, no combinational path from m_axis_tready.
- data_out / m_axis_tlast = entry[rd_ptr]; undefined content while m_axis_tvalid low, but must be stable while m_axis_tvalid high and m_axis_tready low.
- packet_mode=0: m_axis_tvalid = (count != 0).
- packet_mode=1: m_axis_tvalid = (count != 0) & ((pkt_count != 0) | (count == depth)); full-buffer override prevents deadlock on packets longer than depth.
- Full: push blocked; pop in that cycle frees a slot visible next cycle.
- Empty: pop impossible; push in that cycle is visible next cycle (no bypass).
- Once asserted, m_axis_tvalid stays high until pop (AXI rule); holds in both modes since count and pkt_count cannot drop without pop.

## Timing
- Reset: wr_ptr, rd_ptr, count, pkt_count = 0; s_axis_tready = 1, m_axis_tvalid = 0, m_axis_tlast = 0 (entry contents not reset; m_axis_tlast gated low when count==0), data_out don't-care.
- Reset mid-operation: all stored beats discarded, outputs return to reset values next cycle regardless of handshakes in the reset cycle.
- Latency: beat pushed at edge N appears with m_axis_tvalid high after edge N (cycle N+1), mode 0.
- Throughput: sustained 1 beat/cycle with both sides always ready, count steady at 1.
- packet_mode=1: first beat of a packet appears the cycle after its tlast beat is pushed.

## Structure
- Shared package/header: none required beyond clog2 width localparams; keep them local.
- No sub-module; storage is a flop array in this module (depth small).

## Test plan
- Reset, then 8 beats 0x01..0x08 (tlast on 0x08), m_axis_tready=1, depth=4 -> data_out 0x01..0x08 in order, one per cycle, tlast only with 0x08, count never > 1.
- m_axis_tready=0, push 5 beats -> 4 accepted, s_axis_tready low after 4th, count=4; raise tready -> 0x01..0x04 drain, s_axis_tready high cycle after first pop.
- Full buffer, push and pop same cycle -> blocked push (tready low), count 4→3, next cycle push accepted.
- Empty, push and ready same cycle -> no bypass; beat out next cycle, count 0→1→0.
- packet_mode=1: push 0xA0,0xA1,0xA2(tlast) with gaps -> m_axis_tvalid low until cycle after 0xA2 pushed; 6-beat packet into depth 4 -> valid on full, all 6 delivered.
- Reset asserted with count=3, pkt_count=1 -> next cycle count=0, pkt_count=0, m_axis_tvalid=0, s_axis_tready=1.
